// File: rtl/ram_responder.sv
// Word-addressed RAM slave with a fixed wait-state count, request checking and an error state.
// Latency: LAT BUSY cycles, then one ACCESS cycle; read data is valid combinationally during ACCESS.
// Backpressure: the requester holds ramREN/ramWEN until ACCESS; any change while BUSY aborts the operation.

package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int DEPTH = 256
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LAT_C   = 4'(LAT);
  localparam logic [31:0] DEPTH_C = 32'(DEPTH);

  ramstate_t   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] idx_q, idx_d;
  logic        wr_q, wr_d;

  word_t       mem [DEPTH];

  logic [29:0] widx;
  logic        req;
  logic        oob;
  logic        bad;
  logic        mem_we;

  // A request is exactly one enable; bad only when something is actually being asked for.
  assign widx   = ramaddr[31:2];
  assign req    = ramREN ^ ramWEN;
  assign oob    = {2'b00, widx} >= DEPTH_C;
  assign bad    = (ramREN & ramWEN) | (req & ((ramaddr[1:0] != 2'b00) | oob));

  // Next-state logic: start/abort/complete decisions and capture of index and op.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    case (state_q)
      FREE, ACCESS: begin
        if (bad) begin
          state_d = ERROR;
        end else if (req) begin
          idx_d   = widx;
          wr_d    = ramWEN;
          cnt_d   = LAT_C;
          state_d = (LAT_C == 4'd0) ? ACCESS : BUSY;
        end else begin
          state_d = FREE;
        end
      end
      BUSY: begin
        // Any change to the held request cancels the operation without touching memory.
        if (!req || (widx != idx_q) || (ramWEN != wr_q)) begin
          state_d = FREE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = ACCESS;
          end
        end
      end
      ERROR: begin
        if (!ramREN && !ramWEN) begin
          state_d = FREE;
        end
      end
      default: begin
        state_d = FREE;
      end
    endcase
  end

  // State, counter and captured request registers with asynchronous reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= FREE;
      cnt_q   <= 4'd0;
      idx_q   <= 30'd0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
    end
  end

  // Write commits at the edge closing ACCESS; reset forces FREE so an aborted write never lands.
  assign mem_we = (state_q == ACCESS) & wr_q;

  // Storage array; deliberately not reset so contents survive nRST.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[idx_q[AW-1:0]] <= ramstore;
    end
  end

  assign ramload  = ((state_q == ACCESS) && !wr_q) ? mem[idx_q[AW-1:0]] : 32'h0;
  assign ramstate = state_q;

endmodule
